// File: rtl/axi_lite_write_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite single-beat writer engine
// between N_REQ requesters; returns per-requester done/timeout pulses.
module axi_lite_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int START_TMO = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_addr,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ack,
  output logic [N_REQ-1:0]     req_done,
  output logic [N_REQ-1:0]     req_err,
  output logic [31:0]          wr_addr,
  output logic [31:0]          wr_data,
  output logic                 wr_start,
  input  logic                 wr_run,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(START_TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_BUSY
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_tmo;
  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic [IW-1:0]   w_nxt_rr;
  logic            w_launch;
  logic            w_tmo_hit;
  logic            w_fin;

  // Scan downward so the lowest offset from the pointer wins last.
  always_comb begin
    int v_idx;
    v_idx  = 0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_idx = int'(r_rr) + k;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (req_valid[v_idx]) begin
        w_pick = IW'(v_idx);
        w_any  = 1'b1;
      end
    end
  end

  assign w_nxt_rr = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

  assign w_launch  = (r_state == S_IDLE) && w_any && !wr_run;
  assign w_tmo_hit = (r_state == S_WAIT) && !wr_run &&
                     (r_tmo == TW'(START_TMO - 1));
  assign w_fin     = (r_state == S_BUSY) && !wr_run;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_IDLE):   if (w_launch) w_next = S_LAUNCH;
      (r_state == S_LAUNCH): w_next = S_WAIT;
      (r_state == S_WAIT): begin
        if (wr_run)         w_next = S_BUSY;
        else if (w_tmo_hit) w_next = S_IDLE;
      end
      (r_state == S_BUSY):   if (w_fin) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wr_start = (r_state == S_LAUNCH);
    busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rr     <= '0;
      r_idx    <= '0;
      r_tmo    <= '0;
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      req_ack  <= w_launch  ? (N_REQ'(1) << w_pick) : '0;
      req_done <= w_fin     ? (N_REQ'(1) << r_idx)  : '0;
      req_err  <= w_tmo_hit ? (N_REQ'(1) << r_idx)  : '0;
      if (w_launch) begin
        wr_addr <= req_addr[32*w_pick +: 32];
        wr_data <= req_data[32*w_pick +: 32];
        r_idx   <= w_pick;
      end
      if (w_fin || w_tmo_hit) r_rr <= w_nxt_rr;
      if (r_state == S_LAUNCH)
        r_tmo <= '0;
      else if (r_state == S_WAIT && !wr_run)
        r_tmo <= r_tmo + 1'b1;
    end
  end

  assign grant_id = 3'(r_idx);

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Directed bench for axi_lite_write_arbiter with a simple writer model
// that raises wr_run one cycle after wr_start and holds it four cycles.
module tb_axi_lite_write_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_addr = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_err;
  logic [31:0]     wr_addr;
  logic [31:0]     wr_data;
  logic            wr_start;
  logic            wr_run = 1'b0;
  logic            busy;
  logic [2:0]      grant_id;

  int n_vec = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_done = 0;
  int wm_t = 0;
  bit wm_dead = 1'b0;

  axi_lite_write_arbiter #(.N_REQ(N), .START_TMO(TMO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_start(wr_start),
    .wr_run(wr_run), .busy(busy), .grant_id(grant_id)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wm_t   = 0;
      wr_run = 1'b0;
    end else begin
      if (wr_start && wm_t == 0 && !wm_dead) wm_t = 1;
      else if (wm_t > 0)                     wm_t = wm_t + 1;
      wr_run = (wm_t >= 2 && wm_t <= 5);
      if (wm_t >= 6) wm_t = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    if (wr_start)   n_start++;
    if (|req_done)  n_done++;
  endtask

  task automatic wait_start(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (wr_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_fin(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (|req_done || |req_err) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    ARESETn   = 1'b0;
    req_valid = '0;
    tick();
    tick();
    ARESETn = 1'b1;
  endtask

  initial begin
    int d0;
    int s0;
    int k;
    int bad;

    // reset state
    do_reset();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(wr_start), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_addr", wr_addr, 32'd0);

    // single request on requester 2
    req_addr[64 +: 32] = 32'h40;
    req_data[64 +: 32] = 32'hA5;
    req_valid = 4'b0100;
    tick();
    chk("t1_start", 32'(wr_start), 32'd1);
    chk("t1_addr", wr_addr, 32'h40);
    chk("t1_data", wr_data, 32'hA5);
    chk("t1_ack", 32'(req_ack), 32'h4);
    chk("t1_gid", 32'(grant_id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    req_valid = '0;
    tick();
    chk("t1_ack_pulse", 32'(req_ack), 32'd0);
    chk("t1_start_pulse", 32'(wr_start), 32'd0);
    wait_fin("t1_fin");
    chk("t1_done", 32'(req_done), 32'h4);
    chk("t1_idle", 32'(busy), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(req_done), 32'd0);

    // all four held: round robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) req_addr[32*i +: 32] = 32'h100 + 32'(i);
    req_valid = 4'b1111;
    d0 = n_done;
    s0 = n_start;
    for (int g = 0; g < 5; g++) begin
      wait_start($sformatf("t2_start%0d", g));
      chk($sformatf("t2_gid%0d", g), 32'(grant_id), 32'(g % 4));
      chk($sformatf("t2_addr%0d", g), wr_addr, 32'h100 + 32'(g % 4));
      chk($sformatf("t2_ack%0d", g), 32'(req_ack), 32'(1 << (g % 4)));
      chk($sformatf("t2_order%0d", g), 32'(n_done - d0), 32'(g));
      if (g == 4) req_valid = '0;
      wait_fin($sformatf("t2_fin%0d", g));
      chk($sformatf("t2_done%0d", g), 32'(req_done), 32'(1 << (g % 4)));
    end
    chk("t2_nstart", 32'(n_start - s0), 32'd5);

    // pointer at 2 with requests 0 and 1: wrap to 0, then 1
    do_reset();
    req_valid = 4'b0010;
    wait_start("t3_pre_start");
    req_valid = '0;
    wait_fin("t3_pre_fin");
    req_valid = 4'b0011;
    wait_start("t3_start0");
    chk("t3_gid0", 32'(grant_id), 32'd0);
    wait_fin("t3_fin0");
    wait_start("t3_start1");
    chk("t3_gid1", 32'(grant_id), 32'd1);
    req_valid = '0;
    wait_fin("t3_fin1");
    chk("t3_done1", 32'(req_done), 32'h2);

    // writer never runs: timeout error
    do_reset();
    wm_dead = 1'b1;
    req_valid = 4'b0011;
    wait_start("t4_start");
    chk("t4_gid", 32'(grant_id), 32'd0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (|req_err || |req_done) begin
        k = i;
        break;
      end
    end
    chk("t4_lat", 32'(k), 32'(TMO + 1));
    chk("t4_err", 32'(req_err), 32'h1);
    chk("t4_nodone", 32'(req_done), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(req_err), 32'd0);
    chk("t4_next_start", 32'(wr_start), 32'd1);
    chk("t4_next_gid", 32'(grant_id), 32'd1);
    req_valid = '0;
    wm_dead = 1'b0;

    // async reset during BUSY
    do_reset();
    req_valid = 4'b0001;
    wait_start("t5_start");
    req_valid = '0;
    tick();
    tick();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_start", 32'(wr_start), 32'd0);
    chk("t5_addr", wr_addr, 32'd0);
    chk("t5_gid", 32'(grant_id), 32'd0);
    req_addr[32 +: 32] = 32'h77;
    req_valid = 4'b0010;
    tick();
    tick();
    ARESETn = 1'b1;
    wait_start("t5_regrant");
    chk("t5_gid1", 32'(grant_id), 32'd1);
    chk("t5_addr1", wr_addr, 32'h77);
    req_valid = '0;
    wait_fin("t5_fin");
    chk("t5_done", 32'(req_done), 32'h2);

    // data change during transfer is ignored
    req_data[96 +: 32] = 32'h1234_5678;
    req_valid = 4'b1000;
    wait_start("t6_start");
    chk("t6_gid", 32'(grant_id), 32'd3);
    req_valid = '0;
    req_data[96 +: 32] = 32'hDEAD_BEEF;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (wr_data !== 32'h1234_5678) bad++;
      if (|req_done) break;
    end
    chk("t6_hold", 32'(bad), 32'd0);
    chk("t6_done", 32'(req_done), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
